// File: rtl/stoptimer_pkg.sv
// Shared stopwatch types and default sizing, used by the lap controller and the counter.
package stoptimer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned DEF_TICK_DIV  = 4;
  localparam int unsigned DEF_LAP_DEPTH = 4;
endpackage

// File: rtl/lap_fifo.sv
// Synchronous lap-time FIFO: registered storage, head forced to zero when empty, flush input.
module lap_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch sequencer: run/pause/clear FSM, prescaled elapsed counter and lap capture buffer.
//  state | meaning
//  IDLE  | stopped, counter zeroed by reset or clear, waiting for start
//  RUN   | prescaler advancing, elapsed time counting, laps captured
//  PAUSE | counter and prescaler frozen, start resumes with the fractional tick kept
module stopwatch_lap_ctrl
  import stoptimer_pkg::*;
#(
  parameter  int unsigned CNT_W     = DEF_CNT_W,
  parameter  int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter  int unsigned LAP_DEPTH = DEF_LAP_DEPTH,
  localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
  localparam int unsigned LCW       = $clog2(LAP_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             lap_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] elapsed_time_o,
  output logic             running_o,
  output logic [CNT_W-1:0] lap_time_o,
  output logic             lap_valid_o,
  input  logic             lap_ready_i,
  output logic [LCW-1:0]   lap_count_o,
  output logic             lap_overflow_o
);

  sw_state_e        state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             ovf_q, ovf_d;
  logic             count_en, tick, push, pop;
  logic             fifo_full, fifo_empty;

  // A stop or clear takes effect on its own edge, so that edge neither counts nor captures.
  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!clear_i && start_i) state_d = RUN;
      end
      RUN: begin
        if (clear_i)     state_d = IDLE;
        else if (stop_i) state_d = PAUSE;
        else begin
          count_en = 1'b1;
          push     = lap_i;
        end
      end
      PAUSE: begin
        if (clear_i)      state_d = IDLE;
        else if (start_i) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick = count_en && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d   = presc_q;
    elapsed_d = elapsed_q;
    if (clear_i) begin
      presc_d   = '0;
      elapsed_d = '0;
    end else if (tick) begin
      presc_d   = '0;
      elapsed_d = elapsed_q + CNT_W'(1);
    end else if (count_en) begin
      presc_d   = presc_q + PW'(1);
    end
  end

  assign pop   = lap_ready_i & ~clear_i;
  assign ovf_d = clear_i ? 1'b0 : (ovf_q | (push & fifo_full & ~lap_ready_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      elapsed_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      elapsed_q <= elapsed_d;
      ovf_q     <= ovf_d;
    end
  end

  lap_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clear_i),
    .push_i  (push),
    .data_i  (elapsed_q),
    .pop_i   (pop),
    .data_o  (lap_time_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (lap_count_o)
  );

  assign elapsed_time_o = elapsed_q;
  assign running_o      = (state_q == RUN);
  assign lap_valid_o    = ~fifo_empty;
  assign lap_overflow_o = ovf_q;

endmodule
